// File: rtl/multi_one_shot_pkg.sv
// Shared definitions for the multi-channel one-shot pulse generator.
//
// Contents:
//   state_e    - per-channel FSM state (IDLE, PULSE, HOLDOFF)
//   EDGE_*     - trigger edge selection values for the EDGE_MODE parameter
//   cnt_width  - width of the per-channel down-counter

package multi_one_shot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Counter must hold the larger of the two reload values (len-1) without
    // wrapping; never narrower than one bit.
    function automatic int cnt_width(input int pulse_len, input int holdoff);
        int m;
        m = (pulse_len > holdoff) ? pulse_len : holdoff;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/one_shot_channel.sv
// Single trigger channel of the multi-channel one-shot.
//
// Detects the configured edge on 'in', emits a pulse of PULSE_LEN cycles on
// 'out', then optionally locks out further triggers for HOLDOFF cycles.
// Edges that arrive while the channel cannot accept them set a sticky
// 'missed' flag.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-low
//   in         - trigger level
//   en         - channel enable; low forces IDLE on the next edge
//   clr_missed - clears the missed flag (a coincident set wins)
//   out        - one-shot pulse (state == PULSE)
//   busy       - state is PULSE or HOLDOFF
//   missed     - sticky: an edge was ignored

module one_shot_channel
    import multi_one_shot_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter int HOLDOFF   = 0,
    parameter int EDGE_MODE = 0,
    parameter int RETRIGGER = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic en,
    input  logic clr_missed,
    output logic out,
    output logic busy,
    output logic missed
);

    localparam int CntW = cnt_width(PULSE_LEN, HOLDOFF);

    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_LEN - 1);
    // Only meaningful when HOLDOFF > 0; zero otherwise so it never wraps.
    localparam logic [CntW-1:0] HoldLoad  = (HOLDOFF > 0) ? CntW'(HOLDOFF - 1) : '0;

    // The HOLDOFF parameter shadows the enumerator of the same name, so the
    // states are always referenced through the package scope.
    multi_one_shot_pkg::state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_prev_q;
    logic            missed_q, missed_d;
    logic            trig_edge;
    logic            ignored;

    // Edge detect against the previous registered sample.
    always_comb begin
        trig_edge = 1'b0;
        case (EDGE_MODE)
            EDGE_FALL: trig_edge = ~in & in_prev_q;
            EDGE_BOTH: trig_edge = in ^ in_prev_q;
            default:   trig_edge = in & ~in_prev_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ignored = 1'b0;

        if (!en) begin
            // Disable aborts any pulse or holdoff; edges seen while disabled
            // are not counted as missed.
            state_d = multi_one_shot_pkg::IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                multi_one_shot_pkg::IDLE: begin
                    if (trig_edge) begin
                        state_d = multi_one_shot_pkg::PULSE;
                        cnt_d   = PulseLoad;
                    end
                end

                multi_one_shot_pkg::PULSE: begin
                    if (trig_edge && (RETRIGGER != 0)) begin
                        // Extend the pulse seamlessly.
                        cnt_d = PulseLoad;
                    end else begin
                        ignored = trig_edge;
                        if (cnt_q == '0) begin
                            if (HOLDOFF > 0) begin
                                state_d = multi_one_shot_pkg::HOLDOFF;
                                cnt_d   = HoldLoad;
                            end else begin
                                state_d = multi_one_shot_pkg::IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end

                multi_one_shot_pkg::HOLDOFF: begin
                    ignored = trig_edge;
                    if (cnt_q == '0) begin
                        state_d = multi_one_shot_pkg::IDLE;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end

                default: begin
                    state_d = multi_one_shot_pkg::IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Set dominates clear.
        missed_d = ignored | (missed_q & ~clr_missed);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= multi_one_shot_pkg::IDLE;
            cnt_q     <= '0;
            missed_q  <= 1'b0;
            // Load the live input so a level held through reset release is
            // not seen as an edge.
            in_prev_q <= in;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            missed_q  <= missed_d;
            in_prev_q <= in;
        end
    end

    assign out    = (state_q == multi_one_shot_pkg::PULSE);
    assign busy   = (state_q != multi_one_shot_pkg::IDLE);
    assign missed = missed_q;

endmodule

// File: rtl/multi_one_shot.sv
// Multi-channel edge-triggered one-shot pulse generator.
//
// CHANNELS fully independent channels, each turning a trigger edge on its
// 'in' bit into a PULSE_LEN-cycle pulse, with optional holdoff lockout and
// retriggering.
//
// Parameters:
//   CHANNELS  - number of channels (>= 1)
//   PULSE_LEN - pulse width in clk cycles (>= 1)
//   HOLDOFF   - lockout cycles after each pulse (>= 0)
//   EDGE_MODE - EDGE_RISE, EDGE_FALL or EDGE_BOTH
//   RETRIGGER - 1: an edge during a pulse restarts the pulse count
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-low
//   in         - per-channel trigger level
//   en         - per-channel enable
//   clr_missed - per-channel clear of the missed flag
//   out        - per-channel pulse
//   busy       - per-channel PULSE or HOLDOFF
//   missed     - per-channel sticky ignored-edge flag

module multi_one_shot
    import multi_one_shot_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 1,
    parameter int HOLDOFF   = 0,
    parameter int EDGE_MODE = 0,
    parameter int RETRIGGER = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] clr_missed,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] missed
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        one_shot_channel #(
            .PULSE_LEN (PULSE_LEN),
            .HOLDOFF   (HOLDOFF),
            .EDGE_MODE (EDGE_MODE),
            .RETRIGGER (RETRIGGER)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .in         (in[g]),
            .en         (en[g]),
            .clr_missed (clr_missed[g]),
            .out        (out[g]),
            .busy       (busy[g]),
            .missed     (missed[g])
        );
    end

endmodule

// File: tb/tb_multi_one_shot.sv
// Directed bench for multi_one_shot. Several instances with different
// parameter sets share one clock and reset; each is exercised in turn.

module tb_multi_one_shot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // A: 4 channels, PULSE_LEN=3, rising, no holdoff, no retrigger
    logic [3:0] a_in, a_en, a_clr, a_out, a_busy, a_missed;
    // B: mode both, PULSE_LEN=1
    logic b_in, b_en, b_clr, b_out, b_busy, b_missed;
    // C/D: PULSE_LEN=4, retrigger on (C) / off (D), shared input
    logic c_in, c_en, c_clr, c_out, c_busy, c_missed;
    logic d_out, d_busy, d_missed;
    // E: PULSE_LEN=2, HOLDOFF=3
    logic e_in, e_en, e_clr, e_out, e_busy, e_missed;
    // F: falling edge, PULSE_LEN=1
    logic f_in, f_en, f_clr, f_out, f_busy, f_missed;

    int total = 0;
    int bad   = 0;

    multi_one_shot #(.CHANNELS(4), .PULSE_LEN(3), .HOLDOFF(0), .EDGE_MODE(0), .RETRIGGER(0))
    u_a (.clk(clk), .reset(reset), .in(a_in), .en(a_en), .clr_missed(a_clr),
         .out(a_out), .busy(a_busy), .missed(a_missed));

    multi_one_shot #(.CHANNELS(1), .PULSE_LEN(1), .HOLDOFF(0), .EDGE_MODE(2), .RETRIGGER(0))
    u_b (.clk(clk), .reset(reset), .in(b_in), .en(b_en), .clr_missed(b_clr),
         .out(b_out), .busy(b_busy), .missed(b_missed));

    multi_one_shot #(.CHANNELS(1), .PULSE_LEN(4), .HOLDOFF(0), .EDGE_MODE(0), .RETRIGGER(1))
    u_c (.clk(clk), .reset(reset), .in(c_in), .en(c_en), .clr_missed(c_clr),
         .out(c_out), .busy(c_busy), .missed(c_missed));

    multi_one_shot #(.CHANNELS(1), .PULSE_LEN(4), .HOLDOFF(0), .EDGE_MODE(0), .RETRIGGER(0))
    u_d (.clk(clk), .reset(reset), .in(c_in), .en(c_en), .clr_missed(c_clr),
         .out(d_out), .busy(d_busy), .missed(d_missed));

    multi_one_shot #(.CHANNELS(1), .PULSE_LEN(2), .HOLDOFF(3), .EDGE_MODE(0), .RETRIGGER(0))
    u_e (.clk(clk), .reset(reset), .in(e_in), .en(e_en), .clr_missed(e_clr),
         .out(e_out), .busy(e_busy), .missed(e_missed));

    multi_one_shot #(.CHANNELS(1), .PULSE_LEN(1), .HOLDOFF(0), .EDGE_MODE(1), .RETRIGGER(0))
    u_f (.clk(clk), .reset(reset), .in(f_in), .en(f_en), .clr_missed(f_clr),
         .out(f_out), .busy(f_busy), .missed(f_missed));

    // Outputs are sampled 1 time unit after the rising edge; inputs change
    // at the same point and are captured by the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        a_in = 4'b0000; a_en = 4'b1111; a_clr = 4'b0000;
        b_in = 1'b0; b_en = 1'b1; b_clr = 1'b0;
        c_in = 1'b0; c_en = 1'b1; c_clr = 1'b0;
        e_in = 1'b0; e_en = 1'b1; e_clr = 1'b0;
        f_in = 1'b0; f_en = 1'b1; f_clr = 1'b0;

        tick(); tick();
        chk("rst_out",    a_out,    32'h0);
        chk("rst_busy",   a_busy,   32'h0);
        chk("rst_missed", a_missed, 32'h0);
        chk("rst_e_busy", e_busy,   32'h0);

        // Level held high through reset release must not fire.
        a_in = 4'b0001;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_thru_reset", a_out, 32'h0);
        end
        a_in = 4'b0000;
        tick();
        chk("fall_no_pulse", a_out, 32'h0);
        chk("no_missed_yet", a_missed, 32'h0);

        // Rising edge, level held 10 cycles: exactly 3 cycles of out.
        a_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("pulse3_c%0d", i), a_out, (i < 3) ? 32'h1 : 32'h0);
        end
        chk("held_no_missed", a_missed, 32'h0);
        a_in = 4'b0000;
        tick();

        // Edge in final PULSE cycle is ignored and flagged.
        a_in = 4'b0001; tick();
        a_in = 4'b0000; tick();
        tick();
        chk("final_cycle_out", a_out, 32'h1);
        a_in = 4'b0001; tick();
        chk("final_edge_ignored", a_out, 32'h0);
        chk("final_edge_missed", a_missed, 32'h1);
        tick();
        chk("missed_sticky", a_missed, 32'h1);
        a_clr = 4'b0001; tick();
        a_clr = 4'b0000;
        chk("missed_cleared", a_missed, 32'h0);
        a_in = 4'b0000; tick();

        // Edge in first IDLE cycle triggers.
        a_in = 4'b0001; tick();
        a_in = 4'b0000; tick();
        tick();
        tick();
        chk("first_idle_out", a_out, 32'h0);
        a_in = 4'b0001; tick();
        chk("first_idle_trig", a_out, 32'h1);
        chk("first_idle_nomiss", a_missed, 32'h0);
        tick(); tick(); tick();
        chk("first_idle_done", a_out, 32'h0);
        a_in = 4'b0000; tick();

        // All four channels at once.
        a_in = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("all_ch_c%0d", i), a_out, (i < 3) ? 32'hf : 32'h0);
        end
        a_in = 4'b0000; tick();

        // en=0 on channel 0 mid-pulse aborts only channel 0.
        a_in = 4'b1111; tick();
        chk("en_pre", a_out, 32'hf);
        a_en = 4'b1110; tick();
        chk("en_abort_c2", a_out, 32'he);
        tick();
        chk("en_abort_c3", a_out, 32'he);
        tick();
        chk("en_abort_end", a_out, 32'h0);
        a_en = 4'b1111; tick();
        chk("en_restore_no_pulse", a_out, 32'h0);
        chk("en_no_missed", a_missed, 32'h0);
        a_in = 4'b0000; tick();

        // Reset mid-pulse: terminated on that edge, nothing after release.
        a_in = 4'b0001; tick();
        chk("rst_mid_pre", a_out, 32'h1);
        reset = 1'b0; tick();
        chk("rst_mid_out", a_out, 32'h0);
        chk("rst_mid_busy", a_busy, 32'h0);
        reset = 1'b1; tick();
        chk("rst_mid_after", a_out, 32'h0);
        chk("rst_mid_after_busy", a_busy, 32'h0);
        a_in = 4'b0000; tick();

        // Mode both: rise then fall 5 cycles later -> two 1-cycle pulses.
        for (int i = 0; i < 10; i++) begin
            if (i == 0) b_in = 1'b1;
            if (i == 5) b_in = 1'b0;
            tick();
            chk($sformatf("both_c%0d", i), b_out, (i == 0 || i == 5) ? 32'h1 : 32'h0);
        end

        // Falling-edge mode ignores rise, fires on fall.
        f_in = 1'b1; tick();
        chk("fall_rise_ignored", f_out, 32'h0);
        f_in = 1'b0; tick();
        chk("fall_fires", f_out, 32'h1);
        tick();
        chk("fall_one_cycle", f_out, 32'h0);

        // Second edge at pulse cycle 2: retrigger -> 6 cycles, else 4 + missed.
        for (int i = 0; i < 9; i++) begin
            if (i == 0) c_in = 1'b1;
            if (i == 1) c_in = 1'b0;
            if (i == 2) c_in = 1'b1;
            tick();
            chk($sformatf("retrig_c%0d", i), c_out, (i < 6) ? 32'h1 : 32'h0);
            chk($sformatf("noretrig_c%0d", i), d_out, (i < 4) ? 32'h1 : 32'h0);
        end
        chk("retrig_missed", c_missed, 32'h0);
        chk("noretrig_missed", d_missed, 32'h1);

        // Holdoff: edge during lockout ignored, busy for 2+3 cycles.
        for (int i = 0; i < 8; i++) begin
            if (i == 0) e_in = 1'b1;
            if (i == 1) e_in = 1'b0;
            if (i == 3) e_in = 1'b1;
            tick();
            chk($sformatf("hold_out_c%0d", i), e_out, (i < 2) ? 32'h1 : 32'h0);
            chk($sformatf("hold_busy_c%0d", i), e_busy, (i < 5) ? 32'h1 : 32'h0);
        end
        chk("hold_missed", e_missed, 32'h1);
        e_clr = 1'b1; tick();
        e_clr = 1'b0;
        chk("hold_missed_clr", e_missed, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
